calc_muldiv: RTL

Parametrised iterative multiply/divide unit for the calculator datapath, driven by the fast multiplier clock.
- Supports signed and unsigned multiply and divide at any even WIDTH.
- Results go to HI/LO registers.
- Start/busy/done handshake and divide-by-zero reporting.
- Replaces the fixed 32-bit unsigned multiply path; the slow-clock core issues one operation and polls done.

---
 rtl/calc_muldiv_pkg.sv | 29 ++
 rtl/calc_muldiv_if.sv | 30 +++
 rtl/calc_muldiv_step.sv | 38 +++
 rtl/calc_muldiv.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/calc_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM state encoding and small op-decoding helpers.
package calc_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ABS  = 2'b01,
        RUN  = 2'b10,
        FIX  = 2'b11
    } state_t;

    // Bit 0 of the op code selects the signed variant.
    function automatic logic is_signed(input op_t op);
        return op[0];
    endfunction

    // Bit 1 of the op code selects divide over multiply.
    function automatic logic is_div(input op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/calc_muldiv_if.sv
// Request/response bundle between the slow-clock core and the mul/div unit.
//   start/op/a/b : request, driven by the core (master)
//   busy/done    : handshake status from the unit (slave)
//   hi/lo        : result registers; div_zero flags a divide by zero
interface calc_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    import calc_muldiv_pkg::*;

    logic             start;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_zero
    );

endinterface

// File: rtl/calc_muldiv_step.sv
// One radix-2 iteration of the mul/div datapath (purely combinational).
//   acc      : 2*WIDTH accumulator ({partial, multiplier} or {remainder, dividend/quotient})
//   operand  : multiplicand or divisor magnitude
//   div_mode : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_next : accumulator after this step (divide: LSB left at 0)
//   q_bit    : quotient bit produced by a divide step (0 when multiplying)
module calc_muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        acc_next = '0;
        q_bit    = 1'b0;
        // Multiply: conditionally add into the upper half, keep the carry, shift right.
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        // Divide: shift the next dividend bit into the remainder and trial-subtract.
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = rem_sh - {1'b0, operand};
        if (div_mode) begin
            // A borrow out of the trial subtraction means the divisor did not fit.
            q_bit    = ~diff[WIDTH];
            acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/calc_muldiv.sv
// Iterative signed/unsigned multiply and divide with HI/LO result registers.
//   clk1  : multiplier clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : start/op/a/b request in, busy/done/hi/lo/div_zero out
// Fixed latency: done rises WIDTH+2 edges after the accepting edge.
module calc_muldiv
    import calc_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk1,
    input  logic         reset,
    calc_muldiv_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q, b_q, opnd;
    logic [ACC_W-1:0]   acc;
    logic               neg_res, neg_rem;
    logic               busy_q, done_q, div_zero_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic [ACC_W-1:0]   step_acc;
    logic               step_q;
    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [ACC_W-1:0]   prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   hi_d, lo_d;
    logic               dz_d;

    calc_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .div_mode (is_div(op_q)),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // State register.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = ABS;
            ABS:  state_d = RUN;
            RUN:  if (cnt == LAST) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes; the most-negative value maps onto itself, read as unsigned.
    always_comb begin
        sgn   = is_signed(op_q);
        mag_a = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
        mag_b = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
    end

    // Final sign correction and divide-by-zero override.
    always_comb begin
        prod = neg_res ? -acc : acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[ACC_W-1:WIDTH];
        hi_d = prod[ACC_W-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
        dz_d = 1'b0;
        if (is_div(op_q)) begin
            if (b_q == '0) begin
                hi_d = a_q;
                lo_d = '1;
                dz_d = 1'b1;
            end else begin
                hi_d = neg_rem ? -rem : rem;
                lo_d = neg_res ? -quo : quo;
            end
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            op_q       <= OP_MULTU;
            a_q        <= '0;
            b_q        <= '0;
            opnd       <= '0;
            acc        <= '0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    op_q       <= bus.op;
                    a_q        <= bus.a;
                    b_q        <= bus.b;
                    busy_q     <= 1'b1;
                    div_zero_q <= 1'b0;
                end
                ABS: begin
                    acc     <= {WIDTH'(0), mag_a};
                    opnd    <= mag_b;
                    neg_res <= sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_rem <= sgn && a_q[WIDTH-1];
                    cnt     <= '0;
                end
                RUN: begin
                    // Quotient bit enters at the LSB vacated by the divide shift.
                    acc <= step_acc | ACC_W'(step_q);
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    hi_q       <= hi_d;
                    lo_q       <= lo_d;
                    div_zero_q <= dz_d;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = div_zero_q;

endmodule
